// File: rtl/permutation_engine_pkg.sv
// Shared types, constants and helpers for the ASCON permutation engine.
// State layout: x0 occupies bits [319:256], x4 occupies bits [63:0].
package permutation_engine_pkg;

    localparam int STATE_W = 320;
    localparam int WORD_W  = 64;
    localparam int KEY_W   = 128;

    typedef logic [STATE_W-1:0] type_state;

    // The begin key XOR lands on the two words directly after the rate.
    localparam int RATE64_KEY_OFFSET  = 1;
    localparam int RATE128_KEY_OFFSET = 2;
    localparam int KEY_END_WORD       = 3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic int word_lsb(input int w);
        return STATE_W - WORD_W * (w + 1);
    endfunction

    function automatic logic [7:0] round_const(input logic [3:0] r);
        return {4'hF - r, r};
    endfunction

endpackage

// File: rtl/permutation_engine_round.sv
// One combinational ASCON round: constant addition, 5-bit s-box layer, linear diffusion.
module permutation_round
    import permutation_engine_pkg::*;
(
    input  type_state  state_i,
    input  logic [3:0] round_i,
    output type_state  state_o
);

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] b0, b1, b2, b3, b4;
    logic [63:0] c0, c1, c2, c3, c4;
    logic [63:0] s0, s1, s2, s3, s4;

    assign x0 = state_i[319:256];
    assign x1 = state_i[255:192];
    assign x2 = state_i[191:128] ^ {56'd0, round_const(round_i)};
    assign x3 = state_i[127:64];
    assign x4 = state_i[63:0];

    // Bitsliced s-box: input mixing, chi-like core, output mixing.
    assign b0 = x0 ^ x4;
    assign b1 = x1;
    assign b2 = x2 ^ x1;
    assign b3 = x3;
    assign b4 = x4 ^ x3;

    assign c0 = b0 ^ (~b1 & b2);
    assign c1 = b1 ^ (~b2 & b3);
    assign c2 = b2 ^ (~b3 & b4);
    assign c3 = b3 ^ (~b4 & b0);
    assign c4 = b4 ^ (~b0 & b1);

    assign s0 = c0 ^ c4;
    assign s1 = c1 ^ c0;
    assign s2 = ~c2;
    assign s3 = c3 ^ c2;
    assign s4 = c4;

    assign state_o = {s0 ^ ror(s0, 19) ^ ror(s0, 28),
                      s1 ^ ror(s1, 61) ^ ror(s1, 39),
                      s2 ^ ror(s2, 1)  ^ ror(s2, 6),
                      s3 ^ ror(s3, 10) ^ ror(s3, 17),
                      s4 ^ ror(s4, 7)  ^ ror(s4, 41)};

endmodule

// File: rtl/permutation_engine.sv
// ASCON permutation engine: begin-XOR, p^N at UNROLL rounds per clock, end-XOR.
// dbg_state_o is 0 while idle and 1 while rounds are in flight.
module permutation_engine
    import permutation_engine_pkg::*;
#(
    parameter int UNROLL = 1,
    parameter int RATE_W = 64
) (
    input  logic              clock_i,
    input  logic              resetb_i,
    input  logic              start_i,
    input  logic [3:0]        rounds_i,
    input  logic              load_i,
    input  type_state         state_i,
    input  logic [RATE_W-1:0] data_i,
    input  logic [KEY_W-1:0]  key_i,
    input  logic              xor_data_i,
    input  logic              xor_key_beg_i,
    input  logic              xor_key_end_i,
    input  logic              xor_ext_end_i,
    output logic              ready_o,
    output logic              done_o,
    output logic              err_o,
    output type_state         state_o,
    output logic              dbg_state_o
);

    // Handshake: start_i is taken on a rising edge only while ready_o=1. done_o and err_o are
    // one-cycle pulses; ready_o is already 1 in the done_o cycle so operations can chain.

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 4 || UNROLL == 6)) begin : g_bad_unroll
        $error("permutation_engine: UNROLL must be 1, 2, 3, 4 or 6");
    end
    if (!(RATE_W == 64 || RATE_W == 128)) begin : g_bad_rate
        $error("permutation_engine: RATE_W must be 64 or 128");
    end

    localparam int KEY_WORD    = (RATE_W == 128) ? RATE128_KEY_OFFSET : RATE64_KEY_OFFSET;
    localparam int KEY_BEG_LSB = word_lsb(KEY_WORD + 1);
    localparam int KEY_END_LSB = word_lsb(KEY_END_WORD + 1);
    localparam bit N6_OK       = (6 % UNROLL) == 0;
    localparam bit N8_OK       = (8 % UNROLL) == 0;
    localparam bit N12_OK      = (12 % UNROLL) == 0;

    logic [0:0]       fsm_q;
    logic [3:0]       round_q;
    type_state        state_q;
    logic [KEY_W-1:0] key_q;
    logic             key_end_q;
    logic             ext_end_q;
    logic             done_q;
    logic             err_q;

    type_state        begin_state;
    type_state        stepped;
    type_state        finished;
    logic             rounds_ok;
    logic             last_step;

    assign rounds_ok = (rounds_i == 4'd6  && N6_OK) ||
                       (rounds_i == 4'd8  && N8_OK) ||
                       (rounds_i == 4'd12 && N12_OK);

    assign last_step = ({1'b0, round_q} + 5'(UNROLL)) == 5'd12;

    always_comb begin
        begin_state = load_i ? state_i : state_q;
        if (xor_data_i)
            begin_state[STATE_W-1 -: RATE_W] = begin_state[STATE_W-1 -: RATE_W] ^ data_i;
        if (xor_key_beg_i)
            begin_state[KEY_BEG_LSB +: KEY_W] = begin_state[KEY_BEG_LSB +: KEY_W] ^ key_i;
    end

    // Rounds r .. r+UNROLL-1 chained combinationally within one clock.
    for (genvar g = 0; g < UNROLL; g++) begin : g_round
        type_state round_in;
        type_state round_out;
        if (g == 0) begin : g_first
            assign round_in = state_q;
        end else begin : g_next
            assign round_in = g_round[g-1].round_out;
        end
        permutation_round u_round (
            .state_i (round_in),
            .round_i (round_q + 4'(g)),
            .state_o (round_out)
        );
    end

    assign stepped = g_round[UNROLL-1].round_out;

    always_comb begin
        finished = stepped;
        if (key_end_q)
            finished[KEY_END_LSB +: KEY_W] = finished[KEY_END_LSB +: KEY_W] ^ key_q;
        if (ext_end_q)
            finished[0] = ~finished[0];
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q     <= ST_IDLE;
            round_q   <= 4'd0;
            state_q   <= '0;
            key_q     <= '0;
            key_end_q <= 1'b0;
            ext_end_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (fsm_q == ST_IDLE) begin
                if (start_i && rounds_ok) begin
                    state_q   <= begin_state;
                    key_q     <= key_i;
                    key_end_q <= xor_key_end_i;
                    ext_end_q <= xor_ext_end_i;
                    round_q   <= 4'd12 - rounds_i;
                    fsm_q     <= ST_RUN;
                end else if (start_i) begin
                    err_q <= 1'b1;
                end
            end else begin
                round_q <= round_q + 4'(UNROLL);
                if (last_step) begin
                    state_q <= finished;
                    fsm_q   <= ST_IDLE;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= stepped;
                end
            end
        end
    end

    assign ready_o     = (fsm_q == ST_IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign state_o     = state_q;
    assign dbg_state_o = fsm_q[0];

endmodule

// File: tb/tb_permutation_engine.sv
// Self-checking bench: three engine configurations against a word/s-box-table ASCON model.
module tb_permutation_engine;

    localparam int NI = 3;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic rstb = 1'b1;
    always #5 clk = ~clk;

    int un[NI] = '{1, 3, 4};
    int rw[NI] = '{64, 64, 128};

    logic         start_s [NI];
    logic [3:0]   rounds_s[NI];
    logic         load_s  [NI];
    logic [319:0] sin_s   [NI];
    logic [127:0] data_s  [NI];
    logic [127:0] key_s   [NI];
    logic         xd_s    [NI];
    logic         kb_s    [NI];
    logic         ke_s    [NI];
    logic         ee_s    [NI];

    logic         rdy [NI];
    logic         done[NI];
    logic         err [NI];
    logic         dbg [NI];
    logic [319:0] st  [NI];

    permutation_engine #(.UNROLL(1), .RATE_W(64)) u_u1 (
        .clock_i(clk), .resetb_i(rstb), .start_i(start_s[0]), .rounds_i(rounds_s[0]),
        .load_i(load_s[0]), .state_i(sin_s[0]), .data_i(data_s[0][63:0]), .key_i(key_s[0]),
        .xor_data_i(xd_s[0]), .xor_key_beg_i(kb_s[0]), .xor_key_end_i(ke_s[0]),
        .xor_ext_end_i(ee_s[0]), .ready_o(rdy[0]), .done_o(done[0]), .err_o(err[0]),
        .state_o(st[0]), .dbg_state_o(dbg[0]));

    permutation_engine #(.UNROLL(3), .RATE_W(64)) u_u3 (
        .clock_i(clk), .resetb_i(rstb), .start_i(start_s[1]), .rounds_i(rounds_s[1]),
        .load_i(load_s[1]), .state_i(sin_s[1]), .data_i(data_s[1][63:0]), .key_i(key_s[1]),
        .xor_data_i(xd_s[1]), .xor_key_beg_i(kb_s[1]), .xor_key_end_i(ke_s[1]),
        .xor_ext_end_i(ee_s[1]), .ready_o(rdy[1]), .done_o(done[1]), .err_o(err[1]),
        .state_o(st[1]), .dbg_state_o(dbg[1]));

    permutation_engine #(.UNROLL(4), .RATE_W(128)) u_u4 (
        .clock_i(clk), .resetb_i(rstb), .start_i(start_s[2]), .rounds_i(rounds_s[2]),
        .load_i(load_s[2]), .state_i(sin_s[2]), .data_i(data_s[2]), .key_i(key_s[2]),
        .xor_data_i(xd_s[2]), .xor_key_beg_i(kb_s[2]), .xor_key_end_i(ke_s[2]),
        .xor_ext_end_i(ee_s[2]), .ready_o(rdy[2]), .done_o(done[2]), .err_o(err[2]),
        .state_o(st[2]), .dbg_state_o(dbg[2]));

    // ---------------- scoreboard state ----------------
    int           n_vec = 0;
    int           n_err = 0;
    logic [319:0] exp_q[$];
    logic [319:0] model_st[NI];
    int           exp_done[NI] = '{0, 0, 0};
    int           done_cnt[NI] = '{0, 0, 0};

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++)
            if (done[k] === 1'b1) done_cnt[k]++;
    end

    // ---------------- reference model ----------------
    logic [4:0] sbox[32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                             5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                             5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                             5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] model_op(input logic [319:0] src, input logic [127:0] data,
                                              input logic [127:0] key, input int rate,
                                              input bit xd, input bit kb, input bit ke,
                                              input bit ee, input int nr);
        logic [63:0] x[5];
        logic [63:0] y[5];
        logic [4:0]  idx;
        logic [4:0]  sv;
        int          w;
        for (int i = 0; i < 5; i++) x[i] = src[319 - 64*i -: 64];
        if (xd) begin
            if (rate == 128) begin
                x[0] ^= data[127:64];
                x[1] ^= data[63:0];
            end else begin
                x[0] ^= data[63:0];
            end
        end
        if (kb) begin
            w = rate / 64;
            x[w]     ^= key[127:64];
            x[w + 1] ^= key[63:0];
        end
        for (int r = 12 - nr; r < 12; r++) begin
            x[2] ^= 64'((15 - r) * 16 + r);
            for (int b = 0; b < 64; b++) begin
                idx = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
                sv  = sbox[idx];
                for (int i = 0; i < 5; i++) y[i][b] = sv[4 - i];
            end
            x[0] = y[0] ^ ror64(y[0], 19) ^ ror64(y[0], 28);
            x[1] = y[1] ^ ror64(y[1], 61) ^ ror64(y[1], 39);
            x[2] = y[2] ^ ror64(y[2], 1)  ^ ror64(y[2], 6);
            x[3] = y[3] ^ ror64(y[3], 10) ^ ror64(y[3], 17);
            x[4] = y[4] ^ ror64(y[4], 7)  ^ ror64(y[4], 41);
        end
        if (ke) begin
            x[3] ^= key[127:64];
            x[4] ^= key[63:0];
        end
        if (ee) x[4][0] = ~x[4][0];
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [127:0] rand128();
        logic [127:0] v;
        for (int i = 0; i < 4; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic int pick_n(input int k);
        int n;
        do begin
            case ($urandom_range(0, 2))
                0:       n = 6;
                1:       n = 8;
                default: n = 12;
            endcase
        end while (n % un[k] != 0);
        return n;
    endfunction

    // ---------------- checkers ----------------
    task automatic check_st(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_op(input int k, input bit at_negedge, input int nr, input bit load,
                            input logic [319:0] sv, input logic [127:0] dv, input logic [127:0] kv,
                            input bit xd, input bit kb, input bit ke, input bit ee);
        logic [319:0] src;
        if (at_negedge) @(negedge clk);
        sin_s[k]    = sv;
        data_s[k]   = dv;
        key_s[k]    = kv;
        rounds_s[k] = 4'(nr);
        load_s[k]   = load;
        xd_s[k]     = xd;
        kb_s[k]     = kb;
        ke_s[k]     = ke;
        ee_s[k]     = ee;
        start_s[k]  = 1'b1;
        src = load ? sv : model_st[k];
        exp_q.push_back(model_op(src, data_s[k], kv, rw[k], xd, kb, ke, ee, nr));
        @(negedge clk);
        start_s[k] = 1'b0;
        check_bit($sformatf("u%0d_accept_ready", k), rdy[k], 1'b0);
        check_bit($sformatf("u%0d_accept_dbg", k), dbg[k], 1'b1);
    endtask

    task automatic wait_done(input int k, input int exp_edges, input string tag, input int poke_at);
        int           cnt = 0;
        logic [319:0] e;
        exp_done[k]++;
        while (done[k] !== 1'b1 && cnt < 60) begin
            @(negedge clk);
            cnt++;
            if (poke_at != 0 && cnt == poke_at) begin
                sin_s[k]    = rand320();
                rounds_s[k] = 4'd12;
                load_s[k]   = 1'b1;
                start_s[k]  = 1'b1;
            end
            if (poke_at != 0 && cnt == poke_at + 1) begin
                start_s[k] = 1'b0;
                check_bit({tag, "_busy_err"}, err[k], 1'b0);
            end
        end
        check_int({tag, "_latency"}, cnt, exp_edges);
        e = exp_q.pop_front();
        check_st({tag, "_state"}, st[k], e);
        check_bit({tag, "_ready_in_done"}, rdy[k], 1'b1);
        model_st[k] = e;
    endtask

    task automatic illegal_start(input int k, input logic [3:0] nr, input string tag);
        @(negedge clk);
        sin_s[k]    = rand320();
        data_s[k]   = rand128();
        rounds_s[k] = nr;
        load_s[k]   = 1'b1;
        xd_s[k]     = 1'b1;
        start_s[k]  = 1'b1;
        @(negedge clk);
        start_s[k] = 1'b0;
        check_bit({tag, "_err"}, err[k], 1'b1);
        check_bit({tag, "_ready"}, rdy[k], 1'b1);
        check_st({tag, "_state"}, st[k], model_st[k]);
        @(negedge clk);
        check_bit({tag, "_err_clear"}, err[k], 1'b0);
        check_st({tag, "_state_hold"}, st[k], model_st[k]);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [319:0] sv;
        logic [127:0] dv;
        logic [127:0] kv;
        int           nr;
        for (int k = 0; k < NI; k++) begin
            start_s[k] = 1'b0; rounds_s[k] = 4'd0; load_s[k] = 1'b1; sin_s[k] = '0;
            data_s[k] = '0; key_s[k] = '0; xd_s[k] = 1'b0; kb_s[k] = 1'b0;
            ke_s[k] = 1'b0; ee_s[k] = 1'b0; model_st[k] = '0;
        end

        // reset values before any clock edge
        #1 rstb = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            check_st($sformatf("u%0d_rst_state", k), st[k], '0);
            check_bit($sformatf("u%0d_rst_ready", k), rdy[k], 1'b1);
            check_bit($sformatf("u%0d_rst_done", k), done[k], 1'b0);
            check_bit($sformatf("u%0d_rst_err", k), err[k], 1'b0);
            check_bit($sformatf("u%0d_rst_dbg", k), dbg[k], 1'b0);
        end
        @(negedge clk);
        rstb = 1'b1;

        // ASCON-128 initialisation, one round per clock
        kv = 128'h000102030405060708090a0b0c0d0e0f;
        start_op(0, 1'b1, 12, 1'b1, {64'h80400c0600000000, kv, kv}, '0, kv,
                 1'b0, 1'b0, 1'b1, 1'b0);
        wait_done(0, 12, "ascon_init", 0);

        // same 6-round stimulus through UNROLL=3 and UNROLL=1
        sv = rand320(); dv = rand128(); kv = rand128();
        start_op(1, 1'b1, 6, 1'b1, sv, dv, kv, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_done(1, 2, "u3_n6", 0);
        start_op(0, 1'b1, 6, 1'b1, sv, dv, kv, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_done(0, 6, "u1_n6", 0);

        // randomized operations on every configuration, including chaining from the register
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < NI; k++) begin
                nr = pick_n(k);
                start_op(k, 1'b1, nr, 1'($urandom_range(0, 1)), rand320(), rand128(), rand128(),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                wait_done(k, nr / un[k], $sformatf("rand_u%0d_it%0d", k, it), 0);
            end
        end

        // UNROLL=4, rate 128: back-to-back, second start in the done cycle on the fresh result
        start_op(2, 1'b1, 8, 1'b1, rand320(), rand128(), rand128(), 1'b1, 1'b1, 1'b0, 1'b1);
        wait_done(2, 2, "b2b_first", 0);
        start_op(2, 1'b0, 8, 1'b0, rand320(), rand128(), rand128(), 1'b1, 1'b0, 1'b1, 1'b0);
        wait_done(2, 2, "b2b_second", 0);

        // illegal round counts
        illegal_start(1, 4'd8, "u3_n8");
        illegal_start(2, 4'd6, "u4_n6");
        illegal_start(0, 4'd7, "u1_n7");
        illegal_start(0, 4'd15, "u1_n15");

        // start pulsed while running is ignored
        start_op(0, 1'b1, 12, 1'b1, rand320(), rand128(), rand128(), 1'b0, 1'b1, 1'b1, 1'b1);
        wait_done(0, 12, "busy", 3);

        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++)
            check_int($sformatf("u%0d_done_pulses", k), done_cnt[k], exp_done[k]);

        // asynchronous reset in the middle of a 12-round operation
        start_op(0, 1'b1, 12, 1'b1, rand320(), rand128(), rand128(), 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        #2 rstb = 1'b0;
        #1;
        check_st("midrun_rst_state", st[0], '0);
        check_bit("midrun_rst_ready", rdy[0], 1'b1);
        check_bit("midrun_rst_dbg", dbg[0], 1'b0);
        check_bit("midrun_rst_done", done[0], 1'b0);
        void'(exp_q.pop_back());
        for (int k = 0; k < NI; k++) model_st[k] = '0;
        @(negedge clk);
        rstb = 1'b1;
        repeat (15) @(negedge clk);
        check_int("midrun_no_done", done_cnt[0], exp_done[0]);
        for (int k = 0; k < NI; k++)
            check_st($sformatf("u%0d_post_rst_state", k), st[k], '0);

        // recovery: chain from the cleared register
        start_op(0, 1'b1, 8, 1'b0, rand320(), rand128(), rand128(), 1'b1, 1'b1, 1'b0, 1'b1);
        wait_done(0, 8, "post_rst_op", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
